// File: rtl/mux_4_pkg.sv
// mux_4_pkg: shared constants for the write-back data selector.
//   XLEN       - architectural data width, default data path width of mux_4
//   src_sel_e  - encodings of the register-unit write-data source select
package mux_4_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } src_sel_e;

endpackage

// File: rtl/mux_4.sv
// mux_4: write-back data selector with a registered copy and a sticky
// reserved-select flag.
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   Sumador      - PC+4 adder result
//   DataRd       - data-memory read data
//   ALURes       - ALU result
//   RUDataWrSrc  - write-data source select (src_sel_e encoding)
//   MUX4Res      - selected data, purely combinational
//   MUX4ResQ     - MUX4Res delayed by one clock
//   SelErr       - set when the reserved select code is sampled, held until rst
module mux_4
  import mux_4_pkg::*;
#(
  parameter int                WIDTH       = XLEN,
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Sumador,
  input  logic [WIDTH-1:0] DataRd,
  input  logic [WIDTH-1:0] ALURes,
  input  logic [1:0]       RUDataWrSrc,
  output logic [WIDTH-1:0] MUX4Res,
  output logic [WIDTH-1:0] MUX4ResQ,
  output logic             SelErr
);

  // Unknown select bits match none of the legal items and fall into the
  // default branch, so X/Z on the select never leaks onto the data path.
  always_comb begin
    MUX4Res = DEFAULT_VAL;
    case (RUDataWrSrc)
      SRC_ALU: MUX4Res = ALURes;
      SRC_MEM: MUX4Res = DataRd;
      SRC_PC4: MUX4Res = Sumador;
      default: MUX4Res = DEFAULT_VAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MUX4ResQ <= '0;
      SelErr   <= 1'b0;
    end else begin
      MUX4ResQ <= MUX4Res;
      // Sticky: only reset clears it, legal selects never do.
      if (RUDataWrSrc == SRC_RSVD) begin
        SelErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_4.sv
module tb_mux_4;

  localparam int          W    = 32;
  localparam logic [31:0] DEFV = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic [W-1:0]  Sumador;
  logic [W-1:0]  DataRd;
  logic [W-1:0]  ALURes;
  logic [1:0]    RUDataWrSrc;
  logic [W-1:0]  MUX4Res;
  logic [W-1:0]  MUX4ResQ;
  logic          SelErr;

  int total;
  int bad;

  mux_4 #(.WIDTH(W), .DEFAULT_VAL(DEFV)) dut (
    .clk         (clk),
    .rst         (rst),
    .Sumador     (Sumador),
    .DataRd      (DataRd),
    .ALURes      (ALURes),
    .RUDataWrSrc (RUDataWrSrc),
    .MUX4Res     (MUX4Res),
    .MUX4ResQ    (MUX4ResQ),
    .SelErr      (SelErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference selection written from the select table.
  function automatic logic [W-1:0] ref_mux(input logic [1:0] sel,
                                           input logic [W-1:0] pc4,
                                           input logic [W-1:0] mem,
                                           input logic [W-1:0] alu);
    if ($isunknown(sel)) return DEFV;
    if (sel == 2'b00) return alu;
    if (sel == 2'b01) return mem;
    if (sel == 2'b10) return pc4;
    return DEFV;
  endfunction

  task automatic test_reset();
    // asserted at time 0, before any clock edge
    #1;
    total++;
    if (MUX4ResQ !== 32'h0) begin
      bad++; $display("FAIL reset_q: got %h want %h", MUX4ResQ, 32'h0);
    end
    total++;
    if (SelErr !== 1'b0) begin
      bad++; $display("FAIL reset_selerr: got %b want 0", SelErr);
    end
    // held in reset: registered outputs stay 0, comb path keeps tracking
    RUDataWrSrc = 2'b11; ALURes = 32'h1234_5678;
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'h0 || SelErr !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got q=%h err=%b want q=0 err=0", MUX4ResQ, SelErr);
    end
    RUDataWrSrc = 2'b00; #1;
    total++;
    if (MUX4Res !== 32'h1234_5678) begin
      bad++; $display("FAIL reset_comb_track: got %h want %h", MUX4Res, 32'h1234_5678);
    end
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'h0) begin
      bad++; $display("FAIL reset_hold_q: got %h want 0", MUX4ResQ);
    end
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    rst = 1'b0;
    Sumador = 32'hA; DataRd = 32'hB; ALURes = 32'hC; RUDataWrSrc = 2'b00;
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'hC) begin
      bad++; $display("FAIL first_edge_q: got %h want %h", MUX4ResQ, 32'hC);
    end
  endtask

  task automatic test_select_paths();
    @(negedge clk);
    RUDataWrSrc = 2'b00; #1;
    total++;
    if (MUX4Res !== 32'hC) begin
      bad++; $display("FAIL sel00: got %h want %h", MUX4Res, 32'hC);
    end
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'hC) begin
      bad++; $display("FAIL sel00_q: got %h want %h", MUX4ResQ, 32'hC);
    end
    @(negedge clk);
    RUDataWrSrc = 2'b01; #1;
    total++;
    if (MUX4Res !== 32'hB || MUX4ResQ !== 32'hC) begin
      bad++; $display("FAIL sel01: got res=%h q=%h want res=b q=c", MUX4Res, MUX4ResQ);
    end
    @(negedge clk);
    RUDataWrSrc = 2'b10; #1;
    total++;
    if (MUX4Res !== 32'hA || MUX4ResQ !== 32'hB) begin
      bad++; $display("FAIL sel10: got res=%h q=%h want res=a q=b", MUX4Res, MUX4ResQ);
    end
    total++;
    if (SelErr !== 1'b0) begin
      bad++; $display("FAIL legal_no_selerr: got %b want 0", SelErr);
    end
  endtask

  task automatic test_reserved_sticky();
    @(negedge clk);
    RUDataWrSrc = 2'b11; #1;
    total++;
    if (MUX4Res !== DEFV || SelErr !== 1'b0) begin
      bad++; $display("FAIL sel11_comb: got res=%h err=%b want res=%h err=0", MUX4Res, SelErr, DEFV);
    end
    @(posedge clk); #1;
    total++;
    if (SelErr !== 1'b1 || MUX4ResQ !== DEFV) begin
      bad++; $display("FAIL sel11_edge: got err=%b q=%h want err=1 q=%h", SelErr, MUX4ResQ, DEFV);
    end
    @(negedge clk);
    RUDataWrSrc = 2'b00;
    @(posedge clk); #1;
    total++;
    if (SelErr !== 1'b1 || MUX4ResQ !== 32'hC) begin
      bad++; $display("FAIL sticky: got err=%b q=%h want err=1 q=c", SelErr, MUX4ResQ);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    total++;
    if (MUX4ResQ !== 32'h0 || SelErr !== 1'b0) begin
      bad++; $display("FAIL async_rst: got q=%h err=%b want q=0 err=0", MUX4ResQ, SelErr);
    end
    total++;
    if (MUX4Res !== 32'hC) begin
      bad++; $display("FAIL async_rst_comb: got %h want %h", MUX4Res, 32'hC);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_midcycle();
    @(negedge clk);
    RUDataWrSrc = 2'b00; ALURes = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mid_q0: got %h want %h", MUX4ResQ, 32'hFFFF_FFFF);
    end
    #2;
    ALURes = 32'h8000_0000; #1;
    total++;
    if (MUX4Res !== 32'h8000_0000 || MUX4ResQ !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mid_follow: got res=%h q=%h want res=80000000 q=ffffffff", MUX4Res, MUX4ResQ);
    end
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== 32'h8000_0000) begin
      bad++; $display("FAIL mid_q1: got %h want %h", MUX4ResQ, 32'h8000_0000);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   sels [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [W-1:0] pcs  [6] = '{32'h0000_0004, 32'h8000_0008, 32'h0000_000C,
                               32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h1111_1111};
    logic [W-1:0] mems [6] = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0080,
                               32'hFFFF_FF80, 32'h0F0F_0F0F, 32'h2222_2222};
    logic [W-1:0] alus [6] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_8000,
                               32'h0000_0001, 32'h3333_3333, 32'h89AB_CDEF};
    logic [W-1:0] prev;
    logic [W-1:0] exp;
    prev = MUX4ResQ;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      RUDataWrSrc = sels[i]; Sumador = pcs[i]; DataRd = mems[i]; ALURes = alus[i];
      exp = ref_mux(sels[i], pcs[i], mems[i], alus[i]);
      #1;
      total++;
      if (MUX4Res !== exp || MUX4ResQ !== prev) begin
        bad++; $display("FAIL b2b[%0d]: got res=%h q=%h want res=%h q=%h", i, MUX4Res, MUX4ResQ, exp, prev);
      end
      prev = exp;
    end
    @(posedge clk); #1;
    total++;
    if (MUX4ResQ !== prev || SelErr !== 1'b0) begin
      bad++; $display("FAIL b2b_last: got q=%h err=%b want q=%h err=0", MUX4ResQ, SelErr, prev);
    end
  endtask

  task automatic test_x_select();
    logic [1:0]   xs;
    logic [W-1:0] exp;
    @(negedge clk);
    Sumador = 32'hA; DataRd = 32'hB; ALURes = 32'hC;
    xs = 2'bxx;
    RUDataWrSrc = xs;
    exp = ref_mux(xs, 32'hA, 32'hB, 32'hC);
    #1;
    total++;
    if ($isunknown(MUX4Res) || MUX4Res !== exp) begin
      bad++; $display("FAIL x_select: got %h want %h", MUX4Res, exp);
    end
    @(negedge clk);
    rst = 1'b1;
    RUDataWrSrc = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    Sumador = '0; DataRd = '0; ALURes = '0; RUDataWrSrc = 2'b00;
    test_reset();
    test_first_edge();
    test_select_paths();
    test_reserved_sticky();
    test_async_reset();
    test_midcycle();
    test_back_to_back();
    test_x_select();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4.md
MUX_4 -- requirements
Module: mux_4

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits.
REQ-002 Parameter DEFAULT_VAL, default 32'h0000_0000, output value for the unused select code.
REQ-003 clk  input  1  single clock; all sequential elements rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Sumador  input  WIDTH  PC+4 adder result.
REQ-006 DataRd  input  WIDTH  data-memory read data.
REQ-007 ALURes  input  WIDTH  ALU result.
REQ-008 RUDataWrSrc  input  2  register-unit write-data source select.
REQ-009 MUX4Res  output  WIDTH  selected write-back data, combinational.
REQ-010 MUX4ResQ  output  WIDTH  MUX4Res registered one cycle.
REQ-011 SelErr  output  1  sticky flag: select code 2'b11 was sampled.

Function
REQ-012 RUDataWrSrc=2'b00 SHALL drive MUX4Res=ALURes.
REQ-013 RUDataWrSrc=2'b01 SHALL drive MUX4Res=DataRd.
REQ-014 RUDataWrSrc=2'b10 SHALL drive MUX4Res=Sumador.
REQ-015 RUDataWrSrc=2'b11 SHALL drive MUX4Res=DEFAULT_VAL.
REQ-016 MUX4Res SHALL be zero-latency combinational, follow any input change in the same delta cycle, and be independent of clk and rst.
REQ-017 Any select value other than 00/01/10, including X/Z in simulation, SHALL yield DEFAULT_VAL; no latches inferred.
REQ-018 MUX4ResQ SHALL load MUX4Res on every rising clk edge while rst is low; latency exactly 1 cycle, no enable.
REQ-019 SelErr SHALL set on the rising clk edge where RUDataWrSrc==2'b11 and SHALL hold 1 until rst.
REQ-020 Legal select values SHALL never clear SelErr.
REQ-021 All outputs SHALL pass data bits unmodified; no sign extension, truncation or arithmetic.

Reset
REQ-022 rst high SHALL force MUX4ResQ=0 and SelErr=0 immediately, without waiting for clk.
REQ-023 While rst is high, MUX4ResQ and SelErr SHALL stay 0 regardless of inputs; MUX4Res SHALL keep tracking its inputs.
REQ-024 On the first rising clk edge after rst deasserts, MUX4ResQ SHALL capture the current MUX4Res.
REQ-025 rst asserted mid-operation SHALL discard the pending registered value and clear SelErr.

Structure
REQ-026 Select encodings SHALL be defined in the shared package: SRC_ALU=2'b00, SRC_MEM=2'b01, SRC_PC4=2'b10, SRC_RSVD=2'b11.
REQ-027 The package SHALL also hold the XLEN=32 constant, which is used as the WIDTH default.
REQ-028 The combinational selection SHALL be implemented as a single case on the package constants with a default branch.
REQ-029 The registered stage SHALL live in the same module; no sub-module is required.

Verification
REQ-030 Sumador=0xA, DataRd=0xB, ALURes=0xC; select 00 -> MUX4Res=0xC, and MUX4ResQ=0xC one edge later.
REQ-031 Same inputs, select 01 -> MUX4Res=0xB; select 10 -> MUX4Res=0xA; each is visible before the next clk edge.
REQ-032 Select 11 -> MUX4Res=0x0; SelErr=1 after the next edge; returning to 00 keeps SelErr=1.
REQ-033 Assert rst asynchronously between edges with MUX4ResQ=0xC, SelErr=1 -> both read 0 at once; MUX4Res still 0xC.
REQ-034 Select 00, ALURes=0xFFFF_FFFF, change ALURes to 0x8000_0000 mid-cycle -> MUX4Res follows immediately; MUX4ResQ updates only at the edge.
REQ-035 Drive RUDataWrSrc=2'bX -> MUX4Res=DEFAULT_VAL, with no X propagation.
